// File: rtl/mips_debug_console.sv
// Board-level debug controller: step/run/breakpoint CPU clock enable,
// channel selection with optional auto-scan, and paged 7-segment hex display.
module mips_debug_console #(
  parameter int DW       = 32,
  parameter int NCH      = 5,
  parameter int ND       = 4,
  parameter int PCW      = 32,
  parameter int RUN_DIV  = 5000000,
  parameter int SCAN_DIV = 25000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              BTN_STEP,
  input  logic              BTN_RUN,
  input  logic              BTN_NEXT,
  input  logic              BTN_PREV,
  input  logic              BTN_PAGE,
  input  logic              MODE_SCAN,
  input  logic              BP_EN,
  input  logic [PCW-1:0]    BP_ADDR,
  input  logic [PCW-1:0]    PC,
  input  logic [NCH*DW-1:0] CH_DATA,
  output logic              CPU_CE,
  output logic              HALTED,
  output logic [8*ND-1:0]   SEG_OUT,
  output logic [NCH-1:0]    CH_LED
);

  localparam int NPAGE = DW / (4 * ND);
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PGW   = (NPAGE > 1) ? $clog2(NPAGE) : 1;
  localparam int RCW   = $clog2(RUN_DIV);
  localparam int SCW   = $clog2(SCAN_DIV);

  localparam logic [CW-1:0]  CH_LAST   = CW'(NCH - 1);
  localparam logic [PGW-1:0] PG_LAST   = PGW'(NPAGE - 1);
  localparam logic [RCW-1:0] RUN_LAST  = RCW'(RUN_DIV - 1);
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_RUN, S_BREAK} state_t;

  state_t         state, state_n;
  logic [RCW-1:0] run_cnt, run_cnt_n;
  logic           moved, moved_n;
  logic           ce_n;
  logic [SCW-1:0] scan_cnt, scan_cnt_n;
  logic [CW-1:0]  ch, ch_n;
  logic [PGW-1:0] page, page_n;
  logic           bp_hit;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign HALTED = (state == S_BREAK);

  // moved rises at the end of a CE cycle, i.e. once the CPU has actually taken a step.
  assign bp_hit = BP_EN && moved && (PC == BP_ADDR);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= S_IDLE;
      run_cnt <= '0;
      moved   <= 1'b0;
      CPU_CE  <= 1'b0;
    end else begin
      state   <= state_n;
      run_cnt <= run_cnt_n;
      moved   <= moved_n;
      CPU_CE  <= ce_n;
    end
  end

  // CE is registered, so the run pulse is decided in the last count cycle and
  // a break or stop request in that cycle suppresses it.
  always_comb begin
    state_n   = state;
    run_cnt_n = run_cnt;
    moved_n   = moved;
    ce_n      = 1'b0;
    case (state)
      S_IDLE, S_BREAK: begin
        if (BTN_RUN) begin
          state_n   = S_RUN;
          run_cnt_n = '0;
          moved_n   = 1'b0;
        end else if (BTN_STEP) begin
          state_n = S_STEP;
          ce_n    = 1'b1;
        end
      end
      S_STEP: state_n = S_IDLE;
      S_RUN: begin
        if (CPU_CE) moved_n = 1'b1;
        if (BTN_RUN) begin
          state_n   = S_IDLE;
          run_cnt_n = '0;
        end else if (bp_hit) begin
          state_n   = S_BREAK;
          run_cnt_n = '0;
        end else if (run_cnt == RUN_LAST) begin
          run_cnt_n = '0;
          ce_n      = 1'b1;
        end else begin
          run_cnt_n = run_cnt + RCW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    ch_n       = ch;
    page_n     = page;
    scan_cnt_n = scan_cnt;
    if (BTN_NEXT && !BTN_PREV) begin
      ch_n = (ch == CH_LAST) ? '0 : ch + CW'(1);
    end else if (BTN_PREV && !BTN_NEXT) begin
      ch_n = (ch == '0) ? CH_LAST : ch - CW'(1);
    end
    if (!MODE_SCAN || BTN_NEXT || BTN_PREV) begin
      scan_cnt_n = '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt_n = '0;
      ch_n       = (ch == CH_LAST) ? '0 : ch + CW'(1);
    end else begin
      scan_cnt_n = scan_cnt + SCW'(1);
    end
    if (BTN_PAGE) page_n = (page == PG_LAST) ? '0 : page + PGW'(1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ch       <= '0;
      page     <= '0;
      scan_cnt <= '0;
    end else begin
      ch       <= ch_n;
      page     <= page_n;
      scan_cnt <= scan_cnt_n;
    end
  end

  logic [DW-1:0]   ch_word;
  logic [NCH-1:0]  led_n;
  logic [8*ND-1:0] seg_n;
  logic [3:0]      nib;
  logic            dp_lit;

  always_comb begin
    ch_word = '0;
    led_n   = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (ch == CW'(k)) begin
        ch_word  = CH_DATA[k*DW +: DW];
        led_n[k] = 1'b1;
      end
    end
    seg_n  = '1;
    nib    = '0;
    dp_lit = 1'b0;
    for (int unsigned d = 0; d < ND; d++) begin
      nib = '0;
      for (int unsigned p = 0; p < NPAGE; p++) begin
        if (page == PGW'(p)) nib = ch_word[(p*ND + d)*4 +: 4];
      end
      dp_lit = ((d == ND - 1) && HALTED) || ((d == 0) && (page != '0));
      seg_n[d*8 +: 8] = {~dp_lit, hex7(nib)};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      SEG_OUT <= '1;
      CH_LED  <= NCH'(1);
    end else begin
      SEG_OUT <= seg_n;
      CH_LED  <= led_n;
    end
  end

endmodule

// File: tb/tb_mips_debug_console.sv
// Directed self-checking bench for mips_debug_console with a tiny PC model
// that advances by 4 on every CPU_CE cycle (or holds, to emulate a self-loop).
module tb_mips_debug_console;

  localparam int DW = 32, NCH = 5, ND = 4, PCW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              btn_step, btn_run, btn_next, btn_prev, btn_page;
  logic              mode_scan, bp_en;
  logic [PCW-1:0]    bp_addr;
  logic [PCW-1:0]    pc;
  logic [NCH*DW-1:0] ch_data;
  logic              cpu_ce, halted;
  logic [8*ND-1:0]   seg_out;
  logic [NCH-1:0]    ch_led;

  logic              pc_load, pc_hold;
  logic [PCW-1:0]    pc_init;

  int n_checks = 0;
  int n_pass   = 0;

  mips_debug_console #(
    .DW(DW), .NCH(NCH), .ND(ND), .PCW(PCW), .RUN_DIV(4), .SCAN_DIV(8)
  ) dut (
    .CLK(clk), .RST(rst_n),
    .BTN_STEP(btn_step), .BTN_RUN(btn_run), .BTN_NEXT(btn_next),
    .BTN_PREV(btn_prev), .BTN_PAGE(btn_page),
    .MODE_SCAN(mode_scan), .BP_EN(bp_en), .BP_ADDR(bp_addr), .PC(pc),
    .CH_DATA(ch_data),
    .CPU_CE(cpu_ce), .HALTED(halted), .SEG_OUT(seg_out), .CH_LED(ch_led)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pc_load)                pc <= pc_init;
    else if (cpu_ce && !pc_hold) pc <= pc + 32'd4;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int  ce_cnt;
  int  first_ce;
  logic seen;

  initial begin
    rst_n = 1'b0;
    {btn_step, btn_run, btn_next, btn_prev, btn_page, mode_scan, bp_en} = '0;
    bp_addr = '0;
    pc_load = 1'b1; pc_hold = 1'b0; pc_init = '0;
    ch_data = {32'hFEDC0987, 32'h0F1E2D3C, 32'h55AA55AA, 32'h89ABCDEF, 32'h1234ABCD};
    tick_n(2);
    check("rst_ce", cpu_ce, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_seg", seg_out, 32'hFFFFFFFF);
    check("rst_led", ch_led, 5'b00001);
    rst_n = 1'b1; pc_load = 1'b0;
    tick_n(2);

    // single step
    btn_step = 1'b1; tick(); btn_step = 1'b0;
    check("step_ce", cpu_ce, 1'b1);
    ce_cnt = 0;
    for (int i = 0; i < 6; i++) begin tick(); ce_cnt += int'(cpu_ce); end
    check("step_ce_once", ce_cnt, 0);
    check("step_halted", halted, 1'b0);

    // run into breakpoint at 0x10
    pc_init = 32'h0; pc_load = 1'b1; tick(); pc_load = 1'b0;
    bp_en = 1'b1; bp_addr = 32'h10;
    btn_run = 1'b1; tick(); btn_run = 1'b0;
    ce_cnt = 0; first_ce = -1;
    for (int i = 0; i < 30; i++) begin
      if (cpu_ce) begin ce_cnt++; if (first_ce < 0) first_ce = i; end
      tick();
    end
    check("run_first_ce", first_ce, 4);
    check("run_ce_count", ce_cnt, 4);
    check("bp_pc", pc, 32'h10);
    check("bp_halted", halted, 1'b1);
    check("bp_dp_digit3", seg_out[31:24], 8'h08);

    // resume from breakpoint
    btn_run = 1'b1; tick(); btn_run = 1'b0;
    check("resume_halted", halted, 1'b0);
    ce_cnt = 0;
    for (int i = 0; i < 6; i++) begin ce_cnt += int'(cpu_ce); tick(); end
    check("resume_ce", ce_cnt, 1);
    check("resume_pc", pc, 32'h14);
    btn_run = 1'b1; tick(); btn_run = 1'b0;
    ce_cnt = 0;
    for (int i = 0; i < 8; i++) begin ce_cnt += int'(cpu_ce); tick(); end
    check("stop_no_ce", ce_cnt, 0);

    // start on the breakpoint address: first CE still issued, break on next match
    pc_init = 32'h10; pc_load = 1'b1; pc_hold = 1'b1; tick(); pc_load = 1'b0;
    btn_run = 1'b1; tick(); btn_run = 1'b0;
    ce_cnt = 0;
    for (int i = 0; i < 12; i++) begin ce_cnt += int'(cpu_ce); tick(); end
    check("bp_start_ce", ce_cnt, 1);
    check("bp_start_halted", halted, 1'b1);
    bp_en = 1'b0; pc_hold = 1'b0;
    btn_run = 1'b1; tick(); btn_run = 1'b0;
    tick();
    btn_run = 1'b1; tick(); btn_run = 1'b0;
    check("leave_halted", halted, 1'b0);

    // channel navigation
    btn_prev = 1'b1; tick(); btn_prev = 1'b0; tick();
    check("prev_wrap_led", ch_led, 5'b10000);
    check("ch4_seg", seg_out, 32'hC09080F8);
    btn_next = 1'b1; tick(); btn_next = 1'b0; tick();
    check("next_wrap_led", ch_led, 5'b00001);
    btn_next = 1'b1; btn_prev = 1'b1; tick(); btn_next = 1'b0; btn_prev = 1'b0; tick();
    check("both_led", ch_led, 5'b00001);

    // paging
    check("page0_seg", seg_out, 32'h8883C6A1);
    btn_page = 1'b1; tick(); btn_page = 1'b0; tick();
    check("page1_seg", seg_out, 32'hF9A4B019);
    btn_page = 1'b1; tick(); btn_page = 1'b0; tick();
    check("page_wrap_seg", seg_out, 32'h8883C6A1);

    // auto-scan
    mode_scan = 1'b1;
    tick_n(8);  check("scan_s8", ch_led, 5'b00001);
    tick();     check("scan_s9", ch_led, 5'b00010);
    tick_n(24); check("scan_s33", ch_led, 5'b10000);
    tick_n(8);  check("scan_wrap", ch_led, 5'b00001);
    tick_n(4);
    btn_next = 1'b1; tick(); btn_next = 1'b0;
    tick_n(8);  check("scan_clr_hold", ch_led, 5'b00010);
    tick();     check("scan_clr_adv", ch_led, 5'b00100);
    mode_scan = 1'b0;

    // asynchronous reset during RUN, taken on a CE cycle
    btn_run = 1'b1; tick(); btn_run = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (cpu_ce) begin seen = 1'b1; break; end
      tick();
    end
    check("pre_rst_ce_seen", seen, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ce", cpu_ce, 1'b0);
    check("async_rst_halted", halted, 1'b0);
    check("async_rst_seg", seg_out, 32'hFFFFFFFF);
    check("async_rst_led", ch_led, 5'b00001);
    tick();
    rst_n = 1'b1;
    tick_n(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mips_debug_console.md
Name: mips_debug_console

Overview:
Parametrised board-level debug controller for the single-clock MIPS on DE10-Lite. It replaces the fixed button-clock and selector arrangement with:
- a step/run/breakpoint FSM that drives a CPU clock enable;
- NCH-channel data selection with wrap-around navigation and an optional auto-scan mode;
- paged hex display of DW-bit channels across ND seven-segment digits.

It sits between the debounced button block and the CPU, HEX and LED pins.

Parameters:
DW, 32, width of each monitored channel (multiple of 4*ND)
NCH, 5, number of monitored channels (2..16)
ND, 4, number of 7-seg digits driven
PCW, 32, PC width for breakpoint compare
RUN_DIV, 5000000, CLK cycles per CPU step in RUN state (>=2)
SCAN_DIV, 25000000, CLK cycles per channel advance in scan mode (>=2)

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous, active-low reset
BTN_STEP  in  1  single-cycle pulse: execute one instruction
BTN_RUN  in  1  single-cycle pulse: toggle free-run
BTN_NEXT  in  1  single-cycle pulse: next channel
BTN_PREV  in  1  single-cycle pulse: previous channel
BTN_PAGE  in  1  single-cycle pulse: next display page
MODE_SCAN  in  1  level: 1 = auto-advance channels
BP_EN  in  1  level: breakpoint enable
BP_ADDR  in  PCW  breakpoint PC value
PC  in  PCW  current CPU PC
CH_DATA  in  NCH*DW  channel k at bits [k*DW +: DW]
CPU_CE  out  1  CPU clock enable; the CPU advances on the CLK edge where CPU_CE=1
HALTED  out  1  1 while in BREAK state
SEG_OUT  out  8*ND  digit d at [d*8 +: 8], active-low {dp,g,f,e,d,c,b,a}
CH_LED  out  NCH  one-hot current channel

Behaviour:
- Reset (RST=0, async):
  - state=IDLE, CPU_CE=0, HALTED=0;
  - ch=0, page=0, run and scan counters=0, moved=0;
  - SEG_OUT all 1s (blank), CH_LED=1 (channel 0).
- NPAGE = DW/(4*ND). Page p shows nibbles [p*4*ND +: 4*ND]; digit d shows nibble d of that slice.
- FSM states: IDLE, STEP, RUN, BREAK. CPU_CE is registered and is 1 only in the cycles listed below.
  - IDLE:
    - BTN_RUN -> RUN, with counter=0 and moved=0.
    - else BTN_STEP -> STEP.
  - STEP: CPU_CE=1 for exactly this one cycle, then -> IDLE.
  - RUN:
    - Counter counts 0..RUN_DIV-1. In the cycle the counter equals RUN_DIV-1, CPU_CE=1, moved<=1 and the counter wraps to 0.
    - BTN_RUN -> IDLE; no CE in that cycle.
    - If BP_EN=1, moved=1 and PC==BP_ADDR, -> BREAK. No CE in that cycle; this check has priority over the CE pulse.
  - BREAK:
    - HALTED=1.
    - BTN_RUN -> RUN, with moved=0 so the CPU can leave the breakpoint.
    - else BTN_STEP -> STEP.
    - BP_EN falling does not leave BREAK.
- BTN_RUN has priority over BTN_STEP when both arrive in the same cycle. BTN_STEP is ignored in RUN.
- Channel select:
  - BTN_NEXT: ch = (ch==NCH-1) ? 0 : ch+1.
  - BTN_PREV: ch = (ch==0) ? NCH-1 : ch-1.
  - Both in the same cycle: no change.
  - Scan mode (MODE_SCAN=1): scan counter 0..SCAN_DIV-1; at wrap, ch advances as for NEXT.
  - Any NEXT or PREV pulse clears the scan counter. The scan counter is held at 0 while MODE_SCAN=0.
- Page select: BTN_PAGE gives page = (page==NPAGE-1) ? 0 : page+1. Page is held across channel changes.
- Display:
  - SEG_OUT and CH_LED are registered with 1-cycle latency from any change in ch, page or CH_DATA.
  - Hex decode, active-low (segments only): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
  - DP (bit7) of digit ND-1 is 0 (lit) iff HALTED. DP of digit 0 is lit iff page!=0. All other DPs are 1.
- Width rules:
  - ch uses ceil(log2(NCH)) bits and page uses max(1, ceil(log2(NPAGE))) bits.
  - The PC compare uses full PCW width.

Test Plan:
- Release reset with NCH=5, DW=32, ND=4, RUN_DIV=4; pulse BTN_STEP -> exactly one CPU_CE cycle, starting 1 cycle after the pulse; state back to IDLE; HALTED=0.
- BTN_RUN with PC incrementing by 4 per CE and BP_EN=1, BP_ADDR=0x10, PC=0 at start -> CE every 4th cycle; PC stops at 0x10; HALTED=1; no further CE. Then BTN_RUN -> CE resumes and PC reaches 0x14.
- Start RUN with PC already =BP_ADDR and BP_EN=1 -> first CE still issued (moved=0); break occurs only on the next match.
- BTN_PREV at ch=0 -> ch=4, CH_LED=5'b10000. BTN_NEXT at ch=4 -> ch=0. NEXT and PREV in the same cycle -> unchanged.
- CH_DATA ch0=0x1234ABCD, page 0 -> SEG_OUT digits 0..3 = 0xA1,0xC6,0x83,0x88. BTN_PAGE -> 0x99,0xB0,0xA4,0xF9 with digit-0 DP lit (0x19). BTN_PAGE again -> page 0.
- MODE_SCAN=1, SCAN_DIV=8 -> ch advances every 8 cycles, wrapping 4->0. BTN_NEXT at scan count 5 -> ch+1 and the next auto-advance comes 8 cycles later. Assert RST mid-RUN -> all outputs return to reset values asynchronously.
